// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M funct3 encodings, FSM states and special values
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic op_a_signed(input logic [2:0] f3);
        return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared shift/add multiply and restoring divide iteration registers
module muldiv_datapath #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] b_q, b_d;

    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W-1:0] div_diff;
    logic         div_ge;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // the true difference is below b_q when div_ge, so the low W bits are exact
        div_diff  = div_shift[W-1:0] - b_q;

        if (load) begin
            hi_d = '0;
            lo_d = a_in;
            b_d  = b_in;
        end else if (step) begin
            if (is_div) begin
                hi_d = div_ge ? div_diff : div_shift[W-1:0];
                lo_d = {lo_q[W-2:0], div_ge};
            end else begin
                hi_d = mul_sum[W:1];
                lo_d = {mul_sum[0], lo_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit feeding the register-file write port
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 34
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    // 32 CALC iterations plus the two FIX clocks make up the fixed latency
    localparam logic [4:0] CNT_LAST = 5'(LATENCY - 3);

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                fix_ph_q, fix_ph_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [4:0]          rd_lat_q, rd_lat_d;
    logic [XLEN-1:0]     op_a_q, op_a_d;
    logic                b_zero_q, b_zero_d;
    logic                ovf_q, ovf_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [2*XLEN-1:0]   fix_q, fix_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_out_q, rd_out_d;

    logic                dp_load, dp_step;
    logic [XLEN-1:0]     dp_hi, dp_lo;
    logic                in_sa, in_sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix;

    muldiv_datapath #(.W(XLEN)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (funct3_q[2]),
        .a_in   (mag_a),
        .b_in   (mag_b),
        .hi     (dp_hi),
        .lo     (dp_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        funct3_d = funct3_q;
        rd_lat_d = rd_lat_q;
        op_a_d   = op_a_q;
        b_zero_d = b_zero_q;
        ovf_d    = ovf_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        fix_d    = fix_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;

        in_sa = op_a_signed(funct3) && op_a[XLEN-1];
        in_sb = op_b_signed(funct3) && op_b[XLEN-1];
        mag_a = in_sa ? -op_a : op_a;
        mag_b = in_sb ? -op_b : op_b;

        prod_fix = (sign_a_q ^ sign_b_q) ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
        quot_fix = (sign_a_q ^ sign_b_q) ? -dp_lo : dp_lo;
        rem_fix  = sign_a_q ? -dp_hi : dp_hi;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start && !kill) begin
                    funct3_d = funct3;
                    rd_lat_d = rd_in;
                    op_a_d   = op_a;
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    b_zero_d = (op_b == '0);
                    ovf_d    = op_b_signed(funct3) && funct3[2]
                               && (op_a == INT_MIN) && (op_b == DIV0_QUOT);
                    dp_load  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    dp_step = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_FIX;
                        fix_ph_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_FIX: begin
                // FIX spans two clocks: the wide negate is registered before result selection
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (!fix_ph_q) begin
                    fix_d    = funct3_q[2] ? {rem_fix, quot_fix} : prod_fix;
                    fix_ph_d = 1'b1;
                end else begin
                    case (funct3_q)
                        F3_MUL:                        result_d = fix_q[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:  result_d = fix_q[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:               result_d = b_zero_q ? DIV0_QUOT :
                                                                  ovf_q    ? INT_MIN   :
                                                                             fix_q[XLEN-1:0];
                        default:                       result_d = b_zero_q ? op_a_q :
                                                                  ovf_q    ? '0     :
                                                                             fix_q[2*XLEN-1:XLEN];
                    endcase
                    rd_out_d = rd_lat_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            funct3_q <= '0;
            rd_lat_q <= '0;
            op_a_q   <= '0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            fix_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            funct3_q <= funct3_d;
            rd_lat_q <= rd_lat_d;
            op_a_q   <= op_a_d;
            b_zero_q <= b_zero_d;
            ovf_q    <= ovf_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            fix_q    <= fix_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign we_out = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    // presents a request and returns #1 after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res, output logic we,
                             output logic [4:0] rdo, output logic bsy);
        lat = -1; res = '0; we = 1'b0; rdo = '0; bsy = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; res = result; we = we_out; rdo = rd_out; bsy = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (we_out !== 1'b0)  begin miscompares++; $display("FAIL reset_we: got %b want 0", we_out); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result); end
        vectors++; if (rd_out !== 5'd0)  begin miscompares++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mul_busy_after_accept: got %b want 1", busy); end
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (lat != 34)           begin miscompares++; $display("FAIL mul_latency: got %0d want 34", lat); end
        vectors++; if (res !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        vectors++; if (rdo !== 5'd5)        begin miscompares++; $display("FAIL mul_rd: got %0d want 5", rdo); end
        vectors++; if (we !== 1'b1)         begin miscompares++; $display("FAIL mul_we: got %b want 1", we); end
        vectors++; if (bsy !== 1'b0)        begin miscompares++; $display("FAIL mul_busy_in_done: got %b want 0", bsy); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL mul_done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_ops();
        logic [2:0]  fv [10];
        logic [31:0] av [10];
        logic [31:0] bv [10];
        logic [31:0] ev [10];
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        fv[0] = F3_MULHU;  av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; ev[0] = 32'hFFFF_FFFE;
        fv[1] = F3_MULH;   av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF; ev[1] = 32'h0000_0000;
        fv[2] = F3_MULHSU; av[2] = 32'hFFFF_FFFF; bv[2] = 32'd2;         ev[2] = 32'hFFFF_FFFF;
        fv[3] = F3_DIV;    av[3] = 32'h8000_0000; bv[3] = 32'hFFFF_FFFF; ev[3] = 32'h8000_0000;
        fv[4] = F3_REM;    av[4] = 32'h8000_0000; bv[4] = 32'hFFFF_FFFF; ev[4] = 32'h0000_0000;
        fv[5] = F3_REM;    av[5] = 32'hFFFF_FFF9; bv[5] = 32'd2;         ev[5] = 32'hFFFF_FFFF;
        fv[6] = F3_DIV;    av[6] = 32'hFFFF_FFF9; bv[6] = 32'd2;         ev[6] = 32'hFFFF_FFFD;
        fv[7] = F3_DIV;    av[7] = 32'd20;        bv[7] = 32'hFFFF_FFFA; ev[7] = 32'hFFFF_FFFD;
        fv[8] = F3_REM;    av[8] = 32'd20;        bv[8] = 32'hFFFF_FFFA; ev[8] = 32'd2;
        fv[9] = F3_DIVU;   av[9] = 32'hFFFF_FFFF; bv[9] = 32'd1;         ev[9] = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            issue(fv[i], av[i], bv[i], 5'd10 + 5'(i));
            wait_done(lat, res, we, rdo, bsy);
            vectors++;
            if (lat != 34 || res !== ev[i] || rdo !== 5'd10 + 5'(i)) begin
                miscompares++;
                $display("FAIL op_vec%0d: got result %h lat %0d rd %0d want result %h lat 34 rd %0d",
                         i, res, lat, rdo, ev[i], 10 + i);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        issue(F3_DIVU, 32'd1234, 32'd0, 5'd0);
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (lat != 34)             begin miscompares++; $display("FAIL divu0_latency: got %0d want 34", lat); end
        vectors++; if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu0_result: got %h want ffffffff", res); end
        vectors++; if (we !== 1'b0)           begin miscompares++; $display("FAIL divu0_we_rd0: got %b want 0", we); end
        @(posedge clk); #1;
        issue(F3_REMU, 32'd1234, 32'd0, 5'd0);
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (res !== 32'h0000_04D2) begin miscompares++; $display("FAIL remu0_result: got %h want 000004d2", res); end
        @(posedge clk); #1;
        issue(F3_DIV, 32'hFFFF_FFF9, 32'd0, 5'd8);
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_signed_result: got %h want ffffffff", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        issue(F3_MULHU, 32'h8000_0000, 32'd2, 5'd1);
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (res !== 32'd1) begin miscompares++; $display("FAIL b2b_first_result: got %h want 00000001", res); end
        // start presented while done is high
        issue(F3_REMU, 32'd100, 32'd7, 5'd9);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (lat != 34)     begin miscompares++; $display("FAIL b2b_latency: got %0d want 34", lat); end
        vectors++; if (res !== 32'd2) begin miscompares++; $display("FAIL b2b_second_result: got %h want 00000002", res); end
        vectors++; if (rdo !== 5'd9)  begin miscompares++; $display("FAIL b2b_rd: got %0d want 9", rdo); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        issue(F3_MUL, 32'd6, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd999; op_b = 32'd5; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, res, we, rdo, bsy);
        lat = lat + 10;
        vectors++; if (lat != 34)      begin miscompares++; $display("FAIL ignored_latency: got %0d want 34", lat); end
        vectors++; if (res !== 32'd42) begin miscompares++; $display("FAIL ignored_result: got %h want 0000002a", res); end
        vectors++; if (rdo !== 5'd3)   begin miscompares++; $display("FAIL ignored_rd: got %0d want 3", rdo); end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        int seen;
        // kill and start together in IDLE: start must be dropped
        kill = 1'b1;
        issue(F3_DIV, 32'd50, 32'd5, 5'd6);
        kill = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_start_same_cycle: got busy %b want 0", busy); end
        issue(F3_DIV, 32'd100, 32'd7, 5'd4);
        repeat (19) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy: got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        vectors++; if (seen != 0)        begin miscompares++; $display("FAIL kill_no_done: got %0d pulses want 0", seen); end
        vectors++; if (result !== 32'd42) begin miscompares++; $display("FAIL kill_result_kept: got %h want 0000002a", result); end
        vectors++; if (rd_out !== 5'd3)   begin miscompares++; $display("FAIL kill_rd_kept: got %0d want 3", rd_out); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic bsy;
        issue(F3_DIV, 32'hFFFF_FFEC, 32'd6, 5'd7);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL midrst_result: got %h want 0", result); end
        vectors++; if (rd_out !== 5'd0)  begin miscompares++; $display("FAIL midrst_rd: got %0d want 0", rd_out); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(F3_MUL, 32'd3, 32'd4, 5'd2);
        wait_done(lat, res, we, rdo, bsy);
        vectors++; if (lat != 34)      begin miscompares++; $display("FAIL post_rst_latency: got %0d want 34", lat); end
        vectors++; if (res !== 32'd12) begin miscompares++; $display("FAIL post_rst_result: got %h want 0000000c", res); end
        vectors++; if (we !== 1'b1)    begin miscompares++; $display("FAIL post_rst_we: got %b want 1", we); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_ops();
        test_div_zero();
        test_back_to_back();
        test_start_ignored();
        test_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
